// File: rtl/sim_exit_monitor.sv
// -----------------------------------------------------------------------------
// sim_exit_monitor
//
// Simulation-only end-of-test monitor. It reduces the harness success flag,
// an exit-code handshake and a progress heartbeat to one sticky verdict:
// pass, fail with code, timeout or hang. The emulator top level uses done,
// status and exit_code_q to print the result and end the simulation.
//
// Parameters:
//   BLANK_CYCLES  cycles after reset release during which inputs are ignored
//   HANG_LIMIT    heartbeat-free RUN cycles that declare a hang (0 = off)
//   CODE_W        exit code width
//
// Ports:
//   clock        sole clock
//   reset        asynchronous, active-high reset
//   max_cycles   timeout limit, compared against cycle_count (0 = off)
//   io_success   harness success flag (level)
//   exit_valid   exit code offer
//   exit_ready   monitor accepts the exit code (RUN state only)
//   exit_code    code offered with exit_valid
//   heartbeat    one-cycle pulse per unit of forward progress
//   done         verdict reached, sticky until reset
//   status       0 running, 1 io_success, 2 exit 0, 3 exit nonzero,
//                4 timeout, 5 hang
//   exit_code_q  accepted exit code, 0 unless status is 2 or 3
//   cycle_count  cycles since reset release, saturating, frozen once done
// -----------------------------------------------------------------------------
module sim_exit_monitor #(
  parameter int unsigned BLANK_CYCLES = 10,
  parameter int unsigned HANG_LIMIT   = 100000,
  parameter int unsigned CODE_W       = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [63:0]       max_cycles,
  input  logic              io_success,
  input  logic              exit_valid,
  output logic              exit_ready,
  input  logic [CODE_W-1:0] exit_code,
  input  logic              heartbeat,
  output logic              done,
  output logic [2:0]        status,
  output logic [CODE_W-1:0] exit_code_q,
  output logic [63:0]       cycle_count
);

  typedef enum logic [1:0] {
    ST_BLANK,
    ST_RUN,
    ST_DONE
  } state_e;

  typedef enum logic [2:0] {
    VERDICT_RUNNING  = 3'd0,
    VERDICT_SUCCESS  = 3'd1,
    VERDICT_EXIT_OK  = 3'd2,
    VERDICT_EXIT_BAD = 3'd3,
    VERDICT_TIMEOUT  = 3'd4,
    VERDICT_HANG     = 3'd5
  } verdict_e;

  // Counter widths sized to hold LIMIT-1; degenerate limits keep a 1-bit
  // counter that is never consulted.
  localparam int unsigned BLANK_W    = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam int unsigned BLANK_LAST = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;
  localparam int unsigned IDLE_W     = (HANG_LIMIT > 1) ? $clog2(HANG_LIMIT) : 1;
  localparam int unsigned IDLE_LAST  = (HANG_LIMIT > 0) ? HANG_LIMIT - 1 : 0;

  state_e              state, state_n;
  logic [2:0]          status_n;
  logic [CODE_W-1:0]   code_n;
  logic [BLANK_W-1:0]  blank_cnt;
  logic [IDLE_W-1:0]   idle_cnt;
  logic                blank_done;
  logic                hang_hit;
  logic                timeout_hit;

  // With BLANK_CYCLES = 0 the first cycle after reset still sits in BLANK
  // and leaves it at the first edge.
  assign blank_done  = (BLANK_CYCLES == 0) || (blank_cnt == BLANK_W'(BLANK_LAST));

  // idle_cnt == HANG_LIMIT-1 means this is the HANG_LIMIT-th heartbeat-free
  // cycle; a heartbeat in the same cycle rescues it.
  assign hang_hit    = (HANG_LIMIT != 0) && (idle_cnt == IDLE_W'(IDLE_LAST)) && !heartbeat;
  assign timeout_hit = (max_cycles != 64'd0) && (cycle_count == max_cycles);

  // NOTE: every variable gets its hold value first so no path leaves one
  // unassigned, which would infer a latch.
  always_comb begin
    state_n  = state;
    status_n = status;
    code_n   = exit_code_q;
    unique case (state)
      ST_BLANK: begin
        if (blank_done) state_n = ST_RUN;
      end
      ST_RUN: begin
        // Priority chain: only the highest event is recorded.
        if (exit_valid && exit_ready) begin
          state_n  = ST_DONE;
          status_n = (exit_code == '0) ? VERDICT_EXIT_OK : VERDICT_EXIT_BAD;
          code_n   = exit_code;
        end else if (io_success) begin
          state_n  = ST_DONE;
          status_n = VERDICT_SUCCESS;
        end else if (hang_hit) begin
          state_n  = ST_DONE;
          status_n = VERDICT_HANG;
        end else if (timeout_hit) begin
          state_n  = ST_DONE;
          status_n = VERDICT_TIMEOUT;
        end
      end
      default: ; // ST_DONE is terminal
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_BLANK;
      status      <= VERDICT_RUNNING;
      exit_code_q <= '0;
      done        <= 1'b0;
      exit_ready  <= 1'b0;
    end else begin
      state       <= state_n;
      status      <= status_n;
      exit_code_q <= code_n;
      done        <= (state_n == ST_DONE);
      // Drops together with done, so at most one transfer is accepted.
      exit_ready  <= (state_n == ST_RUN);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      blank_cnt <= '0;
    end else if (state == ST_BLANK && !blank_done) begin
      blank_cnt <= blank_cnt + BLANK_W'(1);
    end
  end

  // Held at zero outside RUN, which also clears it on entry to RUN.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idle_cnt <= '0;
    end else if (state != ST_RUN || heartbeat) begin
      idle_cnt <= '0;
    end else if (idle_cnt != IDLE_W'(IDLE_LAST)) begin
      idle_cnt <= idle_cnt + IDLE_W'(1);
    end
  end

  // Freezes on the edge that records a verdict, so a timeout leaves the
  // count equal to max_cycles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cycle_count <= 64'd0;
    end else if (state_n != ST_DONE && cycle_count != '1) begin
      cycle_count <= cycle_count + 64'd1;
    end
  end

endmodule

// File: tb/tb_sim_exit_monitor.sv
// -----------------------------------------------------------------------------
// tb_sim_exit_monitor
//
// Two monitor instances share one set of inputs:
//   dut0: BLANK_CYCLES=10, HANG_LIMIT=0 (hang disabled)
//   dut1: BLANK_CYCLES=3,  HANG_LIMIT=8
// A behavioural model tracks, per instance, the cycles since reset, the
// current heartbeat-free streak and the verdict. Directed scenarios check
// the documented behaviour with constants; the random scenario compares
// every output of both instances against the model every cycle.
// -----------------------------------------------------------------------------
module tb_sim_exit_monitor;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] max_cycles = '0;
  logic        io_success = 1'b0;
  logic        exit_valid = 1'b0;
  logic [31:0] exit_code = '0;
  logic        heartbeat = 1'b0;

  logic        ready_w [2];
  logic        done_w  [2];
  logic [2:0]  status_w[2];
  logic [31:0] code_w  [2];
  logic [63:0] cnt_w   [2];

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  sim_exit_monitor #(.BLANK_CYCLES(10), .HANG_LIMIT(0), .CODE_W(32)) dut0 (
    .clock(clock), .reset(reset), .max_cycles(max_cycles),
    .io_success(io_success), .exit_valid(exit_valid), .exit_ready(ready_w[0]),
    .exit_code(exit_code), .heartbeat(heartbeat), .done(done_w[0]),
    .status(status_w[0]), .exit_code_q(code_w[0]), .cycle_count(cnt_w[0])
  );

  sim_exit_monitor #(.BLANK_CYCLES(3), .HANG_LIMIT(8), .CODE_W(32)) dut1 (
    .clock(clock), .reset(reset), .max_cycles(max_cycles),
    .io_success(io_success), .exit_valid(exit_valid), .exit_ready(ready_w[1]),
    .exit_code(exit_code), .heartbeat(heartbeat), .done(done_w[1]),
    .status(status_w[1]), .exit_code_q(code_w[1]), .cycle_count(cnt_w[1])
  );

  // ---------------------------------------------------------------- model
  logic            m_done  [2];
  logic [2:0]      m_status[2];
  logic [31:0]     m_code  [2];
  longint unsigned m_t     [2];
  int unsigned     m_streak[2];

  function automatic int unsigned blank_of(int i);
    return (i == 0) ? 10 : 3;
  endfunction

  function automatic int unsigned hang_of(int i);
    return (i == 0) ? 0 : 8;
  endfunction

  // The first RUN cycle is the one whose count equals the blanking length
  // (at least one blank cycle always elapses after reset).
  function automatic logic m_run(int i);
    longint unsigned first_run;
    first_run = (blank_of(i) == 0) ? 64'd1 : 64'(blank_of(i));
    return !m_done[i] && (m_t[i] >= first_run);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_done[i] = 1'b0; m_status[i] = 3'd0; m_code[i] = '0;
      m_t[i] = 0; m_streak[i] = 0;
    end
  endtask

  // Advances the model across one rising edge using the current inputs.
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (!m_done[i]) begin
        if (m_run(i)) begin
          m_streak[i] = heartbeat ? 0 : m_streak[i] + 1;
          if (exit_valid) begin
            m_done[i] = 1'b1; m_code[i] = exit_code;
            m_status[i] = (exit_code == 0) ? 3'd2 : 3'd3;
          end else if (io_success) begin
            m_done[i] = 1'b1; m_status[i] = 3'd1;
          end else if (hang_of(i) != 0 && m_streak[i] >= hang_of(i)) begin
            m_done[i] = 1'b1; m_status[i] = 3'd5;
          end else if (max_cycles != 0 && m_t[i] == max_cycles) begin
            m_done[i] = 1'b1; m_status[i] = 3'd4;
          end
        end
        if (!m_done[i] && m_t[i] != 64'hFFFF_FFFF_FFFF_FFFF) m_t[i] = m_t[i] + 1;
      end
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic tick();
    model_step();
    @(negedge clock);
  endtask

  task automatic clear_inputs();
    max_cycles = '0; io_success = 1'b0; exit_valid = 1'b0;
    exit_code = '0; heartbeat = 1'b0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    @(negedge clock);
    #2 reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      total++; if (ready_w[i] !== 1'b0) begin bad++; $display("FAIL reset_ready[%0d] got=%0d want=0", i, ready_w[i]); end
      total++; if (done_w[i] !== 1'b0) begin bad++; $display("FAIL reset_done[%0d] got=%0d want=0", i, done_w[i]); end
      total++; if (status_w[i] !== 3'd0) begin bad++; $display("FAIL reset_status[%0d] got=%0d want=0", i, status_w[i]); end
      total++; if (code_w[i] !== 32'd0) begin bad++; $display("FAIL reset_code[%0d] got=%0h want=0", i, code_w[i]); end
      total++; if (cnt_w[i] !== 64'd0) begin bad++; $display("FAIL reset_count[%0d] got=%0d want=0", i, cnt_w[i]); end
    end
    reset = 1'b0;
    model_reset();
    tick();
    total++; if (cnt_w[0] !== 64'd1) begin bad++; $display("FAIL first_count got=%0d want=1", cnt_w[0]); end
  endtask

  task automatic test_success_after_blank();
    apply_reset();
    io_success = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      total++; if (cnt_w[0] !== 64'(k)) begin bad++; $display("FAIL blank_count k=%0d got=%0d want=%0d", k, cnt_w[0], k); end
      total++; if (done_w[0] !== 1'b0) begin bad++; $display("FAIL blank_done k=%0d got=%0d want=0", k, done_w[0]); end
      total++; if (ready_w[0] !== (k == 10)) begin bad++; $display("FAIL blank_ready k=%0d got=%0d want=%0d", k, ready_w[0], k == 10); end
    end
    tick();
    total++; if (done_w[0] !== 1'b1) begin bad++; $display("FAIL success_done got=%0d want=1", done_w[0]); end
    total++; if (status_w[0] !== 3'd1) begin bad++; $display("FAIL success_status got=%0d want=1", status_w[0]); end
    total++; if (cnt_w[0] !== 64'd10) begin bad++; $display("FAIL success_count got=%0d want=10", cnt_w[0]); end
    total++; if (status_w[1] !== m_status[1]) begin bad++; $display("FAIL success_status_b got=%0d want=%0d", status_w[1], m_status[1]); end
    total++; if (cnt_w[1] !== m_t[1]) begin bad++; $display("FAIL success_count_b got=%0d want=%0d", cnt_w[1], m_t[1]); end
    io_success = 1'b0;
  endtask

  task automatic test_exit_priority();
    apply_reset();
    repeat (10) tick();
    exit_valid = 1'b1; exit_code = 32'h5; io_success = 1'b1;
    tick();
    total++; if (status_w[0] !== 3'd3) begin bad++; $display("FAIL prio_status got=%0d want=3", status_w[0]); end
    total++; if (code_w[0] !== 32'h5) begin bad++; $display("FAIL prio_code got=%0h want=5", code_w[0]); end
    total++; if (ready_w[0] !== 1'b0) begin bad++; $display("FAIL prio_ready got=%0d want=0", ready_w[0]); end
    exit_code = 32'h0; io_success = 1'b0;
    repeat (5) tick();
    total++; if (status_w[0] !== 3'd3) begin bad++; $display("FAIL sticky_status got=%0d want=3", status_w[0]); end
    total++; if (code_w[0] !== 32'h5) begin bad++; $display("FAIL sticky_code got=%0h want=5", code_w[0]); end
    total++; if (cnt_w[0] !== 64'd10) begin bad++; $display("FAIL sticky_count got=%0d want=10", cnt_w[0]); end
    exit_valid = 1'b0;
  endtask

  task automatic test_timeout();
    apply_reset();
    max_cycles = 64'd50;
    for (int k = 0; k < 200 && !done_w[0]; k++) tick();
    total++; if (done_w[0] !== 1'b1) begin bad++; $display("FAIL timeout_done got=%0d want=1", done_w[0]); end
    total++; if (status_w[0] !== 3'd4) begin bad++; $display("FAIL timeout_status got=%0d want=4", status_w[0]); end
    total++; if (cnt_w[0] !== 64'd50) begin bad++; $display("FAIL timeout_count got=%0d want=50", cnt_w[0]); end
    repeat (5) tick();
    total++; if (cnt_w[0] !== 64'd50) begin bad++; $display("FAIL timeout_frozen got=%0d want=50", cnt_w[0]); end
    total++; if (status_w[1] !== m_status[1]) begin bad++; $display("FAIL timeout_status_b got=%0d want=%0d", status_w[1], m_status[1]); end
    total++; if (cnt_w[1] !== m_t[1]) begin bad++; $display("FAIL timeout_count_b got=%0d want=%0d", cnt_w[1], m_t[1]); end
    max_cycles = '0;
  endtask

  task automatic test_hang();
    int early;
    apply_reset();
    early = 0;
    // Pulses every 7 cycles, then every 8 (seven free cycles and a rescue
    // on the eighth), then silence.
    for (int c = 0; c < 140; c++) begin
      heartbeat = (c < 100) ? (c % 7 == 0) : (c % 8 == 0);
      tick();
      if (done_w[1] !== 1'b0) early++;
    end
    total++; if (early != 0) begin bad++; $display("FAIL hang_early got=%0d want=0 early cycles", early); end
    heartbeat = 1'b0;
    // Last pulse at c=136; c=137..139 already free, 5 more complete 8.
    for (int j = 1; j <= 5; j++) begin
      tick();
      total++; if (done_w[1] !== (j == 5)) begin bad++; $display("FAIL hang_done j=%0d got=%0d want=%0d", j, done_w[1], j == 5); end
    end
    total++; if (status_w[1] !== 3'd5) begin bad++; $display("FAIL hang_status got=%0d want=5", status_w[1]); end
    total++; if (cnt_w[1] !== m_t[1]) begin bad++; $display("FAIL hang_count got=%0d want=%0d", cnt_w[1], m_t[1]); end
    total++; if (done_w[0] !== 1'b0) begin bad++; $display("FAIL hang_disabled got=%0d want=0", done_w[0]); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    repeat (30) tick();
    total++; if (cnt_w[0] !== 64'd30) begin bad++; $display("FAIL pre_reset_count got=%0d want=30", cnt_w[0]); end
    total++; if (ready_w[0] !== 1'b1) begin bad++; $display("FAIL pre_reset_ready got=%0d want=1", ready_w[0]); end
    #2 reset = 1'b1;
    #1;
    total++; if (cnt_w[0] !== 64'd0) begin bad++; $display("FAIL async_count got=%0d want=0", cnt_w[0]); end
    total++; if (ready_w[0] !== 1'b0) begin bad++; $display("FAIL async_ready got=%0d want=0", ready_w[0]); end
    total++; if (done_w[1] !== 1'b0 || status_w[1] !== 3'd0) begin bad++; $display("FAIL async_verdict_b got=%0d/%0d want=0/0", done_w[1], status_w[1]); end
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    for (int k = 1; k <= 10; k++) begin
      tick();
      total++; if (ready_w[0] !== (k == 10) || cnt_w[0] !== 64'(k)) begin
        bad++; $display("FAIL reblank k=%0d got=%0d/%0d want=%0d/%0d", k, ready_w[0], cnt_w[0], k == 10, k);
      end
    end
  endtask

  task automatic test_exit_zero_late();
    apply_reset();
    repeat (500) tick();
    exit_valid = 1'b1; exit_code = 32'h0;
    tick();
    exit_valid = 1'b0;
    total++; if (status_w[0] !== 3'd2) begin bad++; $display("FAIL late_status got=%0d want=2", status_w[0]); end
    total++; if (code_w[0] !== 32'h0) begin bad++; $display("FAIL late_code got=%0h want=0", code_w[0]); end
    total++; if (cnt_w[0] !== 64'd500) begin bad++; $display("FAIL late_count got=%0d want=500", cnt_w[0]); end
    total++; if (done_w[0] !== 1'b1) begin bad++; $display("FAIL late_done got=%0d want=1", done_w[0]); end
  endtask

  task automatic test_random();
    int unsigned hb_div;
    for (int ep = 0; ep < 25; ep++) begin
      apply_reset();
      max_cycles = ($urandom_range(0, 3) == 0) ? 64'd0 : 64'($urandom_range(2, 90));
      hb_div = $urandom_range(2, 10);
      for (int cyc = 0; cyc < 120; cyc++) begin
        io_success = ($urandom_range(0, 79) == 0);
        exit_valid = ($urandom_range(0, 59) == 0);
        exit_code  = ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom;
        heartbeat  = ($urandom_range(0, hb_div - 1) == 0);
        tick();
        for (int i = 0; i < 2; i++) begin
          total++; if (ready_w[i] !== m_run(i)) begin bad++; $display("FAIL rand_ready[%0d] ep=%0d cyc=%0d got=%0d want=%0d", i, ep, cyc, ready_w[i], m_run(i)); end
          total++; if (done_w[i] !== m_done[i]) begin bad++; $display("FAIL rand_done[%0d] ep=%0d cyc=%0d got=%0d want=%0d", i, ep, cyc, done_w[i], m_done[i]); end
          total++; if (status_w[i] !== m_status[i]) begin bad++; $display("FAIL rand_status[%0d] ep=%0d cyc=%0d got=%0d want=%0d", i, ep, cyc, status_w[i], m_status[i]); end
          total++; if (code_w[i] !== m_code[i]) begin bad++; $display("FAIL rand_code[%0d] ep=%0d cyc=%0d got=%0h want=%0h", i, ep, cyc, code_w[i], m_code[i]); end
          total++; if (cnt_w[i] !== m_t[i]) begin bad++; $display("FAIL rand_count[%0d] ep=%0d cyc=%0d got=%0d want=%0d", i, ep, cyc, cnt_w[i], m_t[i]); end
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_success_after_blank();
    test_exit_priority();
    test_timeout();
    test_hang();
    test_async_reset();
    test_exit_zero_late();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sim_exit_monitor.md
# sim_exit_monitor

Simulation-only end-of-test monitor that sits directly downstream of the test harness in the emulator top level. It consumes the harness `io_success` flag, an exit-code handshake and a progress heartbeat, and reduces them to one sticky verdict: pass, fail with code, timeout or hang. The emulator top level uses `done`, `status` and `exit_code_q` to print the result and call `$finish`.

## Interface
Parameters:
- `BLANK_CYCLES`, default 10: number of cycles after reset deassertion during which all inputs are ignored.
- `HANG_LIMIT`, default 100000: heartbeat-idle cycle count that declares a hang. A value of 0 disables hang detection.
- `CODE_W`, default 32: width of the exit code.

Ports:
- `clock`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-high reset.
- `max_cycles`  in  64  timeout limit, sampled every cycle. A value of 0 disables the timeout.
- `io_success`  in  1  harness success flag, level.
- `exit_valid`  in  1  exit-code offer.
- `exit_ready`  out  1  monitor accepts the exit code.
- `exit_code`  in  CODE_W  code offered with `exit_valid`.
- `heartbeat`  in  1  one-cycle pulse per unit of forward progress.
- `done`  out  1  verdict reached; sticky.
- `status`  out  3  verdict encoding:
  - 0: running
  - 1: pass via `io_success`
  - 2: pass via exit code 0
  - 3: fail via nonzero exit code
  - 4: timeout
  - 5: hang
- `exit_code_q`  out  CODE_W  accepted exit code; 0 unless status is 2 or 3.
- `cycle_count`  out  64  cycles since reset deassertion; saturates at all-ones; freezes when `done` is set.

## Operation
- The FSM has three states: BLANK, RUN and DONE. Reset forces BLANK.
- BLANK:
  - A blank counter runs from 0.
  - Transition to RUN occurs on the cycle in which the counter equals `BLANK_CYCLES`-1. With `BLANK_CYCLES`=0, the FSM enters RUN on the first cycle.
  - `io_success`, `exit_valid` and `heartbeat` are ignored.
  - `exit_ready`=0.
- RUN:
  - `exit_ready`=1.
  - The events below are evaluated every cycle, highest priority first. Only the highest-priority event is recorded.
    1. Exit transfer (`exit_valid`&&`exit_ready`): capture `exit_code`. Set status=2 if the code is 0, otherwise status=3.
    2. `io_success`=1: status=1.
    3. Hang: the idle counter equals `HANG_LIMIT`-1 and `heartbeat`=0 in this cycle. Result is status=5.
    4. Timeout: `max_cycles`!=0 and `cycle_count`==`max_cycles`. Result is status=4.
  - Any recorded event moves the FSM to DONE.
- DONE:
  - Terminal state; only reset exits it.
  - `exit_ready`=0.
  - All inputs are ignored.
  - `status` and `exit_code_q` hold their values.
- Idle counter:
  - Cleared on reset, on entry to RUN, and in any RUN cycle with `heartbeat`=1.
  - Otherwise increments in RUN.
  - Saturates at `HANG_LIMIT`-1.
- `cycle_count`:
  - Increments every cycle in BLANK and RUN, starting from 0 in the first cycle after reset deassertion.
  - Holds in DONE.
  - Saturating 64-bit arithmetic; it never wraps.
- A reset asserted mid-run returns all state to reset values immediately (asynchronous). The previous verdict is lost.

## Timing
- Reset values: `exit_ready`=0, `done`=0, `status`=0, `exit_code_q`=0, `cycle_count`=0, FSM=BLANK.
- All outputs are registered.
- An event sampled at clock edge N appears on `done`/`status` after edge N, one cycle of latency.
- `exit_ready` drops to 0 in the same cycle `done` rises, so at most one exit transfer is ever accepted.
- Timeout fires when `cycle_count` equals `max_cycles`, so `done` is visible with `cycle_count`=`max_cycles`; the count freezes there.
- Hang fires on the `HANG_LIMIT`-th consecutive heartbeat-free RUN cycle.
- A heartbeat on that same cycle prevents the hang.
- `io_success` asserted during BLANK and still high on the first RUN cycle is recognised on that cycle.

## Test plan
- BLANK_CYCLES=10, `io_success` held high from reset release → `done`=0 through `cycle_count`=10; `done`=1 and `status`=1 on the next edge; `exit_ready` is never 1 during BLANK.
- In RUN, `exit_valid`=1 with `exit_code`=0x5, `io_success`=1 in the same cycle → `status`=3, `exit_code_q`=0x5; a later `exit_valid` with code 0 is not accepted and nothing changes.
- `max_cycles`=50, no other events, HANG_LIMIT=0 → `done`=1, `status`=4, `cycle_count` frozen at 50.
- HANG_LIMIT=8, heartbeat pulses every 7 cycles for 100 cycles, then stop → no hang during the pulse phase; `status`=5 exactly 8 cycles after the last pulse.
- Reset asserted asynchronously mid-cycle while in RUN with `cycle_count`=30 → all outputs 0 immediately without waiting for a clock edge; after release, blanking repeats and counting restarts from 0.
- `max_cycles`=0, HANG_LIMIT=0, exit code 0 offered at cycle 500 → `status`=2, `exit_code_q`=0, `cycle_count`=500.
